// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use hazard detection and pipeline stall/flush/freeze control
//
// Issue-side hazard unit for the 5-stage RV32I pipeline. It keeps a shadow copy of
// the destination and write controls of the instruction admitted into EX. It stalls
// for one cycle on a load-use hazard, flushes on an EX mispredict, freezes the
// pipeline while data memory is busy, and counts stall and flush events with
// saturating counters.
//
// Ports:
//   clk, reset_n                  clock (rising edge), asynchronous active-low reset
//   valid_id .. memread_id        decoded ID-stage instruction fields
//   mispredict_ex                 branch in EX resolved against its prediction
//   dmem_busy                     data memory not ready; MEM cannot complete
//   stall_if, stall_id            hold PC/IF-ID and the ID stage
//   bubble_ex                     load a NOP into ID/EX
//   flush_if_id, flush_id_ex      clear IF/ID and ID/EX
//   freeze_back                   hold ID/EX, EX/MEM and MEM/WB
//   rd_addr_ex, regwrite_ex,
//   memread_ex                    shadow of the instruction in EX
//   stall_count, flush_count      saturating event counters
module hazard_stall_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_id,
  input  logic [REG_W-1:0] rs1_addr_id,
  input  logic [REG_W-1:0] rs2_addr_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [REG_W-1:0] rd_addr_id,
  input  logic             regwrite_id,
  input  logic             memread_id,
  input  logic             mispredict_ex,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_back,
  output logic [REG_W-1:0] rd_addr_ex,
  output logic             regwrite_ex,
  output logic             memread_ex,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [REG_W-1:0] rd_addr_ex_q, rd_addr_ex_d;
  logic             regwrite_ex_q, regwrite_ex_d;
  logic             memread_ex_q, memread_ex_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             load_use;

  // Writes to x0 are tracked in the shadow but can never create a hazard.
  assign load_use = valid_id & memread_ex_q & regwrite_ex_q & (rd_addr_ex_q != '0) &
                    ((rs1_used_id & (rs1_addr_id == rd_addr_ex_q)) |
                     (rs2_used_id & (rs2_addr_id == rd_addr_ex_q)));

  always_comb begin
    state_d       = state_q;
    rd_addr_ex_d  = rd_addr_ex_q;
    regwrite_ex_d = regwrite_ex_q;
    memread_ex_d  = memread_ex_q;
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    bubble_ex     = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    freeze_back   = 1'b0;

    // State only records the wait phase; decisions below use current inputs.
    case (state_q)
      RUN:      if (dmem_busy)  state_d = MEM_WAIT;
      MEM_WAIT: if (!dmem_busy) state_d = RUN;
      default:  state_d = RUN;
    endcase

    // Controls are held low during reset so an abort takes effect immediately.
    if (reset_n) begin
      if (dmem_busy) begin
        // Mispredict is ignored here; its source holds it until the pipeline moves.
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        freeze_back = 1'b1;
      end else if (mispredict_ex) begin
        flush_if_id   = 1'b1;
        flush_id_ex   = 1'b1;
        rd_addr_ex_d  = '0;
        regwrite_ex_d = 1'b0;
        memread_ex_d  = 1'b0;
        if (flush_count_q != CNT_MAX) flush_count_d = flush_count_q + CNT_ONE;
      end else if (load_use) begin
        // Bubble enters EX with an empty shadow, so the retry next cycle proceeds.
        stall_if      = 1'b1;
        stall_id      = 1'b1;
        bubble_ex     = 1'b1;
        rd_addr_ex_d  = '0;
        regwrite_ex_d = 1'b0;
        memread_ex_d  = 1'b0;
        if (stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_ONE;
      end else begin
        rd_addr_ex_d  = rd_addr_id;
        regwrite_ex_d = regwrite_id & valid_id;
        memread_ex_d  = memread_id & valid_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      rd_addr_ex_q  <= '0;
      regwrite_ex_q <= 1'b0;
      memread_ex_q  <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rd_addr_ex_q  <= rd_addr_ex_d;
      regwrite_ex_q <= regwrite_ex_d;
      memread_ex_q  <= memread_ex_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign rd_addr_ex  = rd_addr_ex_q;
  assign regwrite_ex = regwrite_ex_q;
  assign memread_ex  = memread_ex_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid_id, rs1_used_id, rs2_used_id, regwrite_id, memread_id;
  logic [REG_W-1:0] rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic             mispredict_ex, dmem_busy;
  logic             stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze_back;
  logic [REG_W-1:0] rd_addr_ex;
  logic             regwrite_ex, memread_ex;
  logic [CNT_W-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  // Reference: the instruction currently occupying EX plus event tallies.
  int m_rd, m_sc, m_fc;
  bit m_wr, m_ld;

  hazard_stall_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .valid_id(valid_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_addr_id(rd_addr_id), .regwrite_id(regwrite_id), .memread_id(memread_id),
    .mispredict_ex(mispredict_ex), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .freeze_back(freeze_back),
    .rd_addr_ex(rd_addr_ex), .regwrite_ex(regwrite_ex), .memread_ex(memread_ex),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_id(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                        input int rd, input bit wr, input bit ld);
    valid_id    = v;
    rs1_addr_id = r1[REG_W-1:0];
    rs1_used_id = u1;
    rs2_addr_id = r2[REG_W-1:0];
    rs2_used_id = u2;
    rd_addr_id  = rd[REG_W-1:0];
    regwrite_id = wr;
    memread_id  = ld;
  endtask

  function automatic bit hazard();
    bit hit1, hit2;
    hit1 = rs1_used_id && (int'(rs1_addr_id) == m_rd);
    hit2 = rs2_used_id && (int'(rs2_addr_id) == m_rd);
    return valid_id && m_ld && m_wr && (m_rd != 0) && (hit1 || hit2);
  endfunction

  // Expected {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze_back}.
  function automatic logic [5:0] exp_ctrl();
    if (!reset_n)      return 6'b000000;
    if (dmem_busy)     return 6'b110001;
    if (mispredict_ex) return 6'b000110;
    if (hazard())      return 6'b111000;
    return 6'b000000;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ctrl"}, {26'd0, stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze_back},
        {26'd0, exp_ctrl()});
    chk({tag, ".rd_ex"}, rd_addr_ex, m_rd);
    chk({tag, ".wr_ex"}, regwrite_ex, m_wr);
    chk({tag, ".ld_ex"}, memread_ex, m_ld);
    chk({tag, ".scnt"}, stall_count, m_sc);
    chk({tag, ".fcnt"}, flush_count, m_fc);
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_ld = 0; m_sc = 0; m_fc = 0;
  endtask

  // Advance the reference by one clock using the inputs applied this cycle.
  task automatic model_clock();
    if (!reset_n || dmem_busy) return;
    if (mispredict_ex) begin
      m_rd = 0; m_wr = 0; m_ld = 0;
      if (m_fc < CMAX) m_fc++;
    end else if (hazard()) begin
      m_rd = 0; m_wr = 0; m_ld = 0;
      if (m_sc < CMAX) m_sc++;
    end else begin
      m_rd = rd_addr_id;
      m_wr = regwrite_id && valid_id;
      m_ld = memread_id && valid_id;
    end
  endtask

  // Inputs are already applied; check at the falling edge, then clock the model.
  task automatic cyc(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    mispredict_ex = 1'b0;
    dmem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset.ctrl", {stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze_back}, 0);
    chk("reset.scnt", stall_count, 0);
    chk("reset.rd_ex", rd_addr_ex, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // lw x5 ; add x6,x5,x1 -> one bubble, then the add issues.
    set_id(1, 0, 1, 0, 0, 5, 1, 1); cyc("t1.lw");
    set_id(1, 5, 1, 1, 1, 6, 1, 0); cyc("t1.stall");
    chk("t1.scnt_after", stall_count, 1);
    cyc("t1.retry");
    chk("t1.rd_ex_after", rd_addr_ex, 6);

    // lw x0 then a reader of x0; lw x7 then rs2=7 not used -> no stalls.
    set_id(1, 0, 1, 0, 0, 0, 1, 1); cyc("t2.lw0");
    set_id(1, 0, 1, 0, 1, 3, 1, 0); cyc("t2.rd0");
    set_id(1, 0, 1, 0, 0, 7, 1, 1); cyc("t2.lw7");
    set_id(1, 2, 1, 7, 0, 4, 1, 0); cyc("t2.rs2unused");
    chk("t2.scnt", stall_count, 1);

    // Mispredict coincides with a load-use: flush wins.
    set_id(1, 0, 1, 0, 0, 5, 1, 1); cyc("t3.lw");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    mispredict_ex = 1'b1; cyc("t3.flush");
    mispredict_ex = 1'b0;
    chk("t3.fcnt", flush_count, 1);
    chk("t3.rd_ex", rd_addr_ex, 0);

    // Freeze for 3 cycles with load-use and mispredict pending, then flush.
    set_id(1, 0, 1, 0, 0, 5, 1, 1); cyc("t4.lw");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    mispredict_ex = 1'b1;
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("t4.freeze");
    chk("t4.ld_held", memread_ex, 1);
    dmem_busy = 1'b0; cyc("t4.flush");
    mispredict_ex = 1'b0;
    chk("t4.fcnt", flush_count, 2);

    // Reset asserted during a load-use stall cycle aborts it immediately.
    set_id(1, 0, 1, 0, 0, 5, 1, 1); cyc("t6.lw");
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    @(negedge clk);
    check_all("t6.stall");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.inreset");
    chk("t6.stall_if", stall_if, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc("t6.after");
    chk("t6.nostall_cnt", stall_count, 0);

    // Repeated load-use with ID held on "lw x5 reading x5": 17 hazards saturate at 15.
    set_id(1, 5, 1, 0, 0, 5, 1, 1);
    for (int i = 0; i < 34; i++) cyc("t5.sat");
    chk("t5.scnt_sat", stall_count, CMAX);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      mispredict_ex = ($urandom_range(0, 7) == 0);
      dmem_busy     = ($urandom_range(0, 4) == 0);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
